// File: rtl/uart_char_transmitter_if.sv
// ---------------------------------------------------------------------------
// uart_char_transmitter_if
// Bundles the character-side handshake and the serial line of the UART
// transmitter.
//   master : drives sampleTick, dataIn and load; observes dataOut, busy, txDone
//   slave  : the transmitter itself
// Signals
//   sampleTick  baud x OVERSAMPLE enable, one clk wide per tick
//   dataIn      character to send, sampled when load is accepted
//   load        request to send dataIn
//   dataOut     serial line, idles high
//   busy        high while a frame is in flight
//   txDone      one-clk pulse when the final stop bit period ends
// ---------------------------------------------------------------------------
interface uart_char_transmitter_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 sampleTick;
    logic [DATA_BITS-1:0] dataIn;
    logic                 load;
    logic                 dataOut;
    logic                 busy;
    logic                 txDone;

    modport master (
        output sampleTick,
        output dataIn,
        output load,
        input  dataOut,
        input  busy,
        input  txDone
    );

    modport slave (
        input  sampleTick,
        input  dataIn,
        input  load,
        output dataOut,
        output busy,
        output txDone
    );
endinterface

// File: rtl/uart_char_transmitter.sv
// ---------------------------------------------------------------------------
// uart_char_transmitter
// Serial transmit side of the character link. A character offered with a load
// strobe is shifted out as one UART frame: a start bit (0), DATA_BITS data
// bits LSB first, then STOP_BITS stop bits (1). Every bit lasts OVERSAMPLE
// pulses of sampleTick, the same oversampled baud enable used by the receiver.
// Ports
//   clk   system clock, all logic on posedge
//   rst   synchronous reset, active low
//   tx    uart_char_transmitter_if.slave (sampleTick, dataIn, load in;
//         dataOut, busy, txDone out - all outputs registered)
// ---------------------------------------------------------------------------
module uart_char_transmitter #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    uart_char_transmitter_if.slave    tx
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]           state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 data_out_r;
    logic                 busy_r;
    logic                 tx_done_r;
    logic                 period_end;

    // A bit period ends on the tick that would take tickCnt past OVERSAMPLE-1.
    // Ticks seen in IDLE never count, so the first bit always gets a full
    // OVERSAMPLE ticks measured from the accepting edge.
    assign period_end = (state != IDLE) && tx.sampleTick && (tick_cnt == TICK_LAST);

    // Value the shift register takes after the current LSB has been sent;
    // its bit 0 is the next data bit to drive onto the line.
    assign shift_next = shift_reg >> 1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shift_reg  <= '0;
            data_out_r <= 1'b1;
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;

            if ((state != IDLE) && tx.sampleTick) begin
                tick_cnt <= period_end ? '0 : tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    data_out_r <= 1'b1;
                    busy_r     <= 1'b0;
                    if (tx.load && !busy_r) begin
                        // The start bit goes out from the accepting edge; a
                        // coincident sampleTick is deliberately not counted.
                        shift_reg  <= tx.dataIn;
                        tick_cnt   <= '0;
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        busy_r     <= 1'b1;
                        data_out_r <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (period_end) begin
                        bit_cnt    <= '0;
                        data_out_r <= shift_reg[0];
                        state      <= DATA;
                    end
                end

                DATA: begin
                    if (period_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            stop_cnt   <= 1'b0;
                            data_out_r <= 1'b1;
                            state      <= STOP;
                        end else begin
                            shift_reg  <= shift_next;
                            bit_cnt    <= bit_cnt + 1'b1;
                            data_out_r <= shift_next[0];
                        end
                    end
                end

                STOP: begin
                    data_out_r <= 1'b1;
                    if (period_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            // busy drops on the same edge as txDone rises, so a
                            // load held during the txDone clk is taken next edge.
                            busy_r    <= 1'b0;
                            tx_done_r <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    data_out_r <= 1'b1;
                    busy_r     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign tx.dataOut = data_out_r;
    assign tx.busy    = busy_r;
    assign tx.txDone  = tx_done_r;

endmodule

// File: tb/tb_uart_char_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_char_transmitter
// Self-checking bench for uart_char_transmitter (8 data bits, x16, 1 stop).
// A frame-level reference model (tick count since accept -> bit index of the
// frame) is compared with the DUT every clock; table vectors and directed
// sequences add explicit checks on line pattern, frame length and corners.
// ---------------------------------------------------------------------------
module tb_uart_char_transmitter;

    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int SB    = 1;
    localparam int TOTAL = (1 + DB + SB) * OS;

    logic clk;
    logic rst;

    uart_char_transmitter_if #(.DATA_BITS(DB)) ifc ();

    uart_char_transmitter #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .STOP_BITS (SB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: whether a frame is in flight, the character,
    // and how many sampleTicks have elapsed since it was accepted.
    logic         m_busy  = 1'b0;
    logic         m_line  = 1'b1;
    logic         m_done  = 1'b0;
    int           m_ticks = 0;
    logic [DB-1:0] m_frame = '0;

    function automatic logic frame_bit(input int idx, input logic [DB-1:0] fr);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return fr[idx-1];
        return 1'b1;
    endfunction

    function automatic void model_step(input logic r, input logic t, input logic l,
                                       input logic [DB-1:0] d);
        if (!r) begin
            m_busy = 1'b0; m_line = 1'b1; m_done = 1'b0; m_ticks = 0;
            return;
        end
        m_done = 1'b0;
        if (!m_busy) begin
            m_line = 1'b1;
            if (l) begin
                m_busy = 1'b1; m_frame = d; m_ticks = 0; m_line = 1'b0;
            end
        end else if (t) begin
            m_ticks++;
            if (m_ticks == TOTAL) begin
                m_busy = 1'b0; m_done = 1'b1; m_line = 1'b1;
            end else begin
                m_line = frame_bit(m_ticks / OS, m_frame);
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive at the negedge, advance model at posedge, compare at
    // the following negedge.
    task automatic cycle(input logic r, input logic t, input logic l, input logic [DB-1:0] d);
        rst = r; ifc.sampleTick = t; ifc.load = l; ifc.dataIn = d;
        @(posedge clk);
        model_step(r, t, l, d);
        @(negedge clk);
        checks++;
        if (ifc.dataOut !== m_line || ifc.busy !== m_busy || ifc.txDone !== m_done) begin
            errors++;
            $display("FAIL model_cmp t=%0t got line=%b busy=%b done=%b expected line=%b busy=%b done=%b",
                     $time, ifc.dataOut, ifc.busy, ifc.txDone, m_line, m_busy, m_done);
        end
    endtask

    // Send one character with a tick every p clocks (first tick before edge
    // E_p after the accept edge E_0). Samples the line mid-slot and returns
    // the slot pattern (slot k in bit k) and the clocks until txDone.
    task automatic run_frame(input logic [DB-1:0] d, input int p, input int mid_load,
                             output logic [9:0] got, output int len);
        int budget;
        int idx;
        budget = TOTAL * p + 50;
        got = '1;
        len = -1;
        cycle(1'b1, 1'b0, 1'b1, d);
        chk("accept_line_low", {31'd0, ifc.dataOut}, 32'd0);
        chk("accept_busy",     {31'd0, ifc.busy},    32'd1);
        for (int j = 1; j <= budget; j++) begin
            cycle(1'b1, (j % p) == 0, j == mid_load,
                  (j == mid_load) ? 8'hFF : 8'($urandom));
            if ((j % (OS * p)) == (OS * p / 2)) begin
                idx = j / (OS * p);
                if (idx < 10) got[idx] = ifc.dataOut;
            end
            if (ifc.txDone === 1'b1) begin
                len = j;
                break;
            end
        end
        if (len < 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: no txDone within %0d clk (data=%0h)", budget, d);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         period;
        int         mid_load;
        logic [9:0] exp_line;
        int         exp_len;
    } vec_t;

    vec_t vecs[6];

    logic [9:0] got_line;
    int         got_len;
    logic       saw_done;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // slot pattern = {stop, data[7:0], start}, slot 0 in bit 0
        vecs[0] = '{8'hA5, 1,  0, 10'b1101001010, 160};
        vecs[1] = '{8'h55, 4,  0, 10'b1010101010, 640};
        vecs[2] = '{8'h3C, 1, 50, 10'b1001111000, 160};
        vecs[3] = '{8'hC3, 2,  0, 10'b1110000110, 320};
        vecs[4] = '{8'h00, 1,  0, 10'b1000000000, 160};
        vecs[5] = '{8'hFF, 3,  0, 10'b1111111110, 480};

        rst = 1'b0; ifc.sampleTick = 1'b0; ifc.load = 1'b0; ifc.dataIn = '0;
        @(negedge clk);

        // Reset held with load and tick high: nothing may start.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'hA5);
            chk("reset_line",   {31'd0, ifc.dataOut}, 32'd1);
            chk("reset_busy",   {31'd0, ifc.busy},    32'd0);
            chk("reset_txdone", {31'd0, ifc.txDone},  32'd0);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        chk("idle_after_reset", {30'd0, ifc.busy, ifc.dataOut}, 32'd1);

        // Table vectors: pattern, frame length, idle afterwards.
        foreach (vecs[i]) begin
            run_frame(vecs[i].data, vecs[i].period, vecs[i].mid_load, got_line, got_len);
            chk($sformatf("vec%0d_line", i), {22'd0, got_line}, {22'd0, vecs[i].exp_line});
            chk($sformatf("vec%0d_len", i), got_len, vecs[i].exp_len);
            chk($sformatf("vec%0d_busy_fall", i), {31'd0, ifc.busy}, 32'd0);
            saw_done = 1'b0;
            for (int k = 0; k < 20; k++) begin
                cycle(1'b1, 1'b1, 1'b0, 8'h00);
                if (ifc.txDone === 1'b1) saw_done = 1'b1;
            end
            chk($sformatf("vec%0d_single_done", i), {31'd0, saw_done}, 32'd0);
        end

        // Back-to-back: load held in the txDone clk is accepted the next edge.
        run_frame(8'h01, 1, 0, got_line, got_len);
        chk("b2b_first_line", {22'd0, got_line}, {22'd0, 10'b1000000010});
        chk("b2b_first_len", got_len, 160);
        run_frame(8'h80, 1, 0, got_line, got_len);
        chk("b2b_second_line", {22'd0, got_line}, {22'd0, 10'b1100000000});
        chk("b2b_second_len", got_len, 160);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);

        // Reset during data bit 3 (slot 4, clk 64..79 after accept).
        cycle(1'b1, 1'b0, 1'b1, 8'h5A);
        for (int j = 1; j <= 70; j++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("midrst_line",   {31'd0, ifc.dataOut}, 32'd1);
        chk("midrst_busy",   {31'd0, ifc.busy},    32'd0);
        chk("midrst_txdone", {31'd0, ifc.txDone},  32'd0);
        saw_done = 1'b0;
        for (int j = 0; j < 200; j++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h00);
            if (ifc.txDone === 1'b1 || ifc.dataOut !== 1'b1) saw_done = 1'b1;
        end
        chk("midrst_no_frame", {31'd0, saw_done}, 32'd0);
        run_frame(8'hC3, 1, 0, got_line, got_len);
        chk("after_rst_line", {22'd0, got_line}, {22'd0, 10'b1110000110});
        chk("after_rst_len", got_len, 160);

        // Random traffic against the reference model.
        for (int j = 0; j < 6000; j++) begin
            cycle(($urandom % 400) != 0, ($urandom % 3) == 0, ($urandom % 6) == 0,
                  8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
